// File: rtl/mini_mips_mem_responder.sv
// ---------------------------------------------------------------------------
// mini_mips_mem_responder
//
// Memory-side responder for the 8-bit multicycle MIPS core. It holds a
// byte-addressed unified instruction/data store, owns the boot sequence and
// exposes one memory-mapped output register.
//
// After reset the block sits in LOAD and holds the core in reset. A byte
// stream is written to consecutive addresses from 0. The byte flagged with
// load_last moves the block to RUN, which releases the core. In RUN the
// core reads combinationally and stores synchronously. Only reset leaves RUN.
//
// Parameters
//   DEPTH      memory bytes (address width fixed at 8)
//   IO_ADDR    address of the output register; never backed by RAM in RUN
//   CNT_WIDTH  width of the saturating run-cycle counter
//
// Ports
//   clk         clock, all state updates on the rising edge
//   reset       synchronous, active-low reset
//   adr         core byte address
//   writedata   core store data
//   memwrite    core store strobe
//   memdata     read data to the core (0 while loading)
//   load_valid  loader byte valid
//   load_data   loader byte
//   load_last   marks the final loader byte
//   load_ready  loader byte accepted when load_valid & load_ready
//   cpu_reset   active-high reset to the core
//   io_out      output register contents
//   io_strobe   one-cycle pulse after each store to IO_ADDR
//   load_wrap   sticky: the load pointer wrapped past 255
//   run_cycles  cycles spent in RUN, saturating at all-ones
// ---------------------------------------------------------------------------
module mini_mips_mem_responder #(
  parameter int              DEPTH     = 256,
  parameter logic [7:0]      IO_ADDR   = 8'hFF,
  parameter int              CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [7:0]           adr,
  input  logic [7:0]           writedata,
  input  logic                 memwrite,
  output logic [7:0]           memdata,
  input  logic                 load_valid,
  input  logic [7:0]           load_data,
  input  logic                 load_last,
  output logic                 load_ready,
  output logic                 cpu_reset,
  output logic [7:0]           io_out,
  output logic                 io_strobe,
  output logic                 load_wrap,
  output logic [CNT_WIDTH-1:0] run_cycles
);

  typedef enum logic {
    LOAD = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t               state_reg;
  state_t               state_next;

  logic [7:0]           ptr_reg;
  logic [7:0]           io_out_reg;
  logic                 io_strobe_reg;
  logic                 load_wrap_reg;
  logic [CNT_WIDTH-1:0] run_cycles_reg;

  // Unified instruction/data store. Contents survive reset on purpose so a
  // reboot can reuse data left behind by a previous run.
  logic [7:0]           mem [DEPTH];

  // Decoded control for this cycle.
  logic                 load_accept;
  logic                 io_store;
  logic                 mem_we;
  logic [7:0]           mem_waddr;
  logic [7:0]           mem_wdata;

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg <= LOAD;
    end else begin
      state_reg <= state_next;
    end
  end

  // -------------------------------------------------------------------------
  // Next state, handshake outputs and write-port decode
  // -------------------------------------------------------------------------
  always_comb begin
    state_next  = state_reg;
    load_ready  = 1'b0;
    cpu_reset   = 1'b1;
    memdata     = 8'h00;
    load_accept = 1'b0;
    io_store    = 1'b0;
    mem_we      = 1'b0;
    mem_waddr   = ptr_reg;
    mem_wdata   = load_data;

    unique case (state_reg)
      LOAD: begin
        // The core is held in reset, so its bus is ignored entirely.
        load_ready  = 1'b1;
        cpu_reset   = 1'b1;
        load_accept = load_valid;
        mem_we      = load_valid;
        mem_waddr   = ptr_reg;
        mem_wdata   = load_data;
        if (load_valid && load_last) begin
          state_next = RUN;
        end
      end
      RUN: begin
        cpu_reset = 1'b0;
        // Zero-latency read; the output register shadows its RAM byte.
        if (adr == IO_ADDR) begin
          memdata = io_out_reg;
        end else begin
          memdata = mem[adr];
        end
        if (memwrite) begin
          if (adr == IO_ADDR) begin
            io_store = 1'b1;
          end else begin
            mem_we    = 1'b1;
            mem_waddr = adr;
            mem_wdata = writedata;
          end
        end
      end
      default: begin
        state_next = LOAD;
      end
    endcase

    // Reset wins over any load or store presented at the same edge.
    if (!reset) begin
      mem_we      = 1'b0;
      load_accept = 1'b0;
      io_store    = 1'b0;
    end
  end

  // -------------------------------------------------------------------------
  // Memory write port (no reset: contents are retained)
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  // -------------------------------------------------------------------------
  // Load pointer and sticky wrap flag
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      ptr_reg       <= 8'h00;
      load_wrap_reg <= 1'b0;
    end else if (load_accept) begin
      ptr_reg <= ptr_reg + 8'd1;
      // The byte landing at the top address is the one that wraps the pointer.
      if (ptr_reg == 8'hFF) begin
        load_wrap_reg <= 1'b1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Output register and its strobe
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      io_out_reg    <= 8'h00;
      io_strobe_reg <= 1'b0;
    end else begin
      // Strobe follows every IO store, so back-to-back stores hold it high.
      io_strobe_reg <= io_store;
      if (io_store) begin
        io_out_reg <= writedata;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Saturating RUN cycle counter
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      run_cycles_reg <= '0;
    end else if (state_reg == RUN && run_cycles_reg != '1) begin
      run_cycles_reg <= run_cycles_reg + CNT_WIDTH'(1);
    end
  end

  assign io_out     = io_out_reg;
  assign io_strobe  = io_strobe_reg;
  assign load_wrap  = load_wrap_reg;
  assign run_cycles = run_cycles_reg;

endmodule

// File: tb/tb_mini_mips_mem_responder.sv
module tb_mini_mips_mem_responder;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance (CNT_WIDTH = 16)
  logic        reset = 1'b0;
  logic [7:0]  adr = 8'h00;
  logic [7:0]  writedata = 8'h00;
  logic        memwrite = 1'b0;
  logic [7:0]  memdata;
  logic        load_valid = 1'b0;
  logic [7:0]  load_data = 8'h00;
  logic        load_last = 1'b0;
  logic        load_ready;
  logic        cpu_reset;
  logic [7:0]  io_out;
  logic        io_strobe;
  logic        load_wrap;
  logic [15:0] run_cycles;

  // Saturation instance (CNT_WIDTH = 4)
  logic        reset2 = 1'b0;
  logic        load_valid2 = 1'b0;
  logic [7:0]  load_data2 = 8'h00;
  logic        load_last2 = 1'b0;
  logic [7:0]  memdata2;
  logic        load_ready2;
  logic        cpu_reset2;
  logic [7:0]  io_out2;
  logic        io_strobe2;
  logic        load_wrap2;
  logic [3:0]  run_cycles2;

  mini_mips_mem_responder #(.DEPTH(256), .IO_ADDR(8'hFF), .CNT_WIDTH(16)) dut (
    .clk(clk), .reset(reset), .adr(adr), .writedata(writedata),
    .memwrite(memwrite), .memdata(memdata), .load_valid(load_valid),
    .load_data(load_data), .load_last(load_last), .load_ready(load_ready),
    .cpu_reset(cpu_reset), .io_out(io_out), .io_strobe(io_strobe),
    .load_wrap(load_wrap), .run_cycles(run_cycles)
  );

  mini_mips_mem_responder #(.DEPTH(256), .IO_ADDR(8'hFF), .CNT_WIDTH(4)) dut_sat (
    .clk(clk), .reset(reset2), .adr(8'h00), .writedata(8'h00),
    .memwrite(1'b0), .memdata(memdata2), .load_valid(load_valid2),
    .load_data(load_data2), .load_last(load_last2), .load_ready(load_ready2),
    .cpu_reset(cpu_reset2), .io_out(io_out2), .io_strobe(io_strobe2),
    .load_wrap(load_wrap2), .run_cycles(run_cycles2)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic [31:0] exp;
  } sb_t;
  sb_t sbq[$];

  typedef struct {
    logic [7:0] adr;
    logic       we;
    logic [7:0] wd;
    logic       chk_rd;
    logic [7:0] exp_rd;
    logic       exp_strobe;
    logic [7:0] exp_io;
  } vec_t;
  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end else begin
      $display("ok   %s = %0h", name, act);
    end
  endtask

  task automatic sb_push(input string name, input logic [31:0] exp);
    sb_t e;
    e.name = name;
    e.exp  = exp;
    sbq.push_back(e);
  endtask

  task automatic sb_pop(input logic [31:0] act);
    sb_t e;
    if (sbq.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_empty actual=%0h required=none", act);
    end else begin
      e = sbq.pop_front();
      check(e.name, act, e.exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_byte(input logic [7:0] d, input logic last);
    load_valid = 1'b1;
    load_data  = d;
    load_last  = last;
    tick();
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  // Combinational read check, then one clock.
  task automatic read_chk(input string name, input logic [7:0] a, input logic [7:0] exp);
    adr      = a;
    memwrite = 1'b0;
    #1;
    check(name, {24'h0, memdata}, {24'h0, exp});
    tick();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  function automatic logic [7:0] wrap_val(input int i);
    return 8'((i * 7 + 3) & 255);
  endfunction

  initial begin
    logic [7:0] boot [4];
    boot[0] = 8'h80; boot[1] = 8'h44; boot[2] = 8'h00; boot[3] = 8'h03;

    //             adr    we    wd     chk   rd     stb   io
    vecs[0]  = '{8'h00, 1'b0, 8'h00, 1'b1, 8'h80, 1'b0, 8'h00};
    vecs[1]  = '{8'h01, 1'b0, 8'h00, 1'b1, 8'h44, 1'b0, 8'h00};
    vecs[2]  = '{8'h02, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 8'h00};
    vecs[3]  = '{8'h03, 1'b0, 8'h00, 1'b1, 8'h03, 1'b0, 8'h00};
    vecs[4]  = '{8'h10, 1'b1, 8'hA5, 1'b0, 8'h00, 1'b0, 8'h00};
    vecs[5]  = '{8'h10, 1'b0, 8'h00, 1'b1, 8'hA5, 1'b0, 8'h00};
    vecs[6]  = '{8'hFF, 1'b1, 8'h3C, 1'b1, 8'h00, 1'b1, 8'h3C};
    vecs[7]  = '{8'hFF, 1'b0, 8'h00, 1'b1, 8'h3C, 1'b0, 8'h3C};
    vecs[8]  = '{8'h10, 1'b1, 8'h5A, 1'b1, 8'hA5, 1'b0, 8'h3C};
    vecs[9]  = '{8'h10, 1'b0, 8'h00, 1'b1, 8'h5A, 1'b0, 8'h3C};
    vecs[10] = '{8'hFF, 1'b1, 8'h11, 1'b1, 8'h3C, 1'b1, 8'h11};
    vecs[11] = '{8'hFF, 1'b1, 8'h22, 1'b1, 8'h11, 1'b1, 8'h22};
    vecs[12] = '{8'h20, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h22};
    vecs[13] = '{8'h10, 1'b1, 8'hA5, 1'b1, 8'h5A, 1'b0, 8'h22};

    // ---------------- reset state ----------------
    reset  = 1'b0;
    reset2 = 1'b0;
    tick();
    tick();
    check("rst_cpu_reset", {31'h0, cpu_reset}, 32'd1);
    check("rst_load_ready", {31'h0, load_ready}, 32'd1);
    check("rst_io_out", {24'h0, io_out}, 32'd0);
    check("rst_io_strobe", {31'h0, io_strobe}, 32'd0);
    check("rst_load_wrap", {31'h0, load_wrap}, 32'd0);
    check("rst_run_cycles", {16'h0, run_cycles}, 32'd0);
    check("rst_memdata", {24'h0, memdata}, 32'd0);
    reset = 1'b1;

    // ---------------- boot handshake ----------------
    for (int i = 0; i < 4; i++) begin
      load_valid = 1'b1;
      load_data  = boot[i];
      load_last  = (i == 3);
      #1;
      check($sformatf("boot%0d_cpu_reset", i), {31'h0, cpu_reset}, 32'd1);
      tick();
      load_valid = 1'b0;
      load_last  = 1'b0;
    end
    check("boot_cpu_reset_released", {31'h0, cpu_reset}, 32'd0);
    check("boot_load_ready_low", {31'h0, load_ready}, 32'd0);
    check("boot_run_cycles_0", {16'h0, run_cycles}, 32'd0);
    tick();
    check("first_run_cycle_count", {16'h0, run_cycles}, 32'd1);

    // ---------------- table-driven RUN traffic ----------------
    for (int i = 0; i < 14; i++) begin
      adr       = vecs[i].adr;
      memwrite  = vecs[i].we;
      writedata = vecs[i].wd;
      if (vecs[i].chk_rd) sb_push($sformatf("vec%0d_memdata", i), {24'h0, vecs[i].exp_rd});
      sb_push($sformatf("vec%0d_io_strobe", i), {31'h0, vecs[i].exp_strobe});
      sb_push($sformatf("vec%0d_io_out", i), {24'h0, vecs[i].exp_io});
      #1;
      if (vecs[i].chk_rd) sb_pop({24'h0, memdata});
      tick();
      memwrite = 1'b0;
      sb_pop({31'h0, io_strobe});
      sb_pop({24'h0, io_out});
    end

    // ---------------- load_valid ignored in RUN ----------------
    adr        = 8'h00;
    load_valid = 1'b1;
    load_data  = 8'hEE;
    load_last  = 1'b1;
    tick();
    load_valid = 1'b0;
    load_last  = 1'b0;
    read_chk("run_ignore_load_mem0", 8'h00, 8'h80);
    read_chk("run_ignore_load_mem3", 8'h03, 8'h03);
    tick();
    tick();
    check("run_cycles_20", {16'h0, run_cycles}, 32'd20);

    // ---------------- reset mid-run, with concurrent store ----------------
    adr        = 8'h10;
    writedata  = 8'h77;
    memwrite   = 1'b1;
    load_valid = 1'b1;
    load_data  = 8'h66;
    do_reset();
    memwrite   = 1'b0;
    load_valid = 1'b0;
    check("midrun_cpu_reset", {31'h0, cpu_reset}, 32'd1);
    check("midrun_io_out", {24'h0, io_out}, 32'd0);
    check("midrun_run_cycles", {16'h0, run_cycles}, 32'd0);
    check("midrun_load_ready", {31'h0, load_ready}, 32'd1);
    load_byte(8'h99, 1'b1);
    check("reload_cpu_reset", {31'h0, cpu_reset}, 32'd0);
    read_chk("reload_mem10_kept", 8'h10, 8'hA5);
    read_chk("reload_mem0", 8'h00, 8'h99);

    // ---------------- wrap: 257 bytes ----------------
    do_reset();
    for (int i = 1; i <= 255; i++) load_byte(wrap_val(i), 1'b0);
    check("wrap_flag_before_255", {31'h0, load_wrap}, 32'd0);
    load_byte(wrap_val(256), 1'b0);
    check("wrap_flag_set", {31'h0, load_wrap}, 32'd1);
    check("wrap_still_loading", {31'h0, cpu_reset}, 32'd1);
    load_byte(8'hC7, 1'b1);
    check("wrap_in_run", {31'h0, cpu_reset}, 32'd0);
    read_chk("wrap_mem0", 8'h00, 8'hC7);
    read_chk("wrap_mem1", 8'h01, wrap_val(2));
    read_chk("wrap_mem10", 8'h10, wrap_val(17));
    read_chk("wrap_memFE", 8'hFE, wrap_val(255));
    read_chk("wrap_io_shadow", 8'hFF, 8'h00);
    check("wrap_flag_sticky", {31'h0, load_wrap}, 32'd1);
    do_reset();
    check("wrap_flag_cleared", {31'h0, load_wrap}, 32'd0);

    // ---------------- saturation (CNT_WIDTH = 4) ----------------
    reset2      = 1'b1;
    load_valid2 = 1'b1;
    load_data2  = 8'h01;
    load_last2  = 1'b1;
    tick();
    load_valid2 = 1'b0;
    load_last2  = 1'b0;
    check("sat_cpu_reset", {31'h0, cpu_reset2}, 32'd0);
    for (int i = 0; i < 14; i++) tick();
    check("sat_count_14", {28'h0, run_cycles2}, 32'd14);
    for (int i = 0; i < 6; i++) tick();
    check("sat_hold_F", {28'h0, run_cycles2}, 32'd15);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mini_mips_mem_responder.md
# mini_mips_mem_responder

Memory-side responder for the 8-bit multicycle MIPS core: it answers the core's `adr`/`memwrite`/`writedata` requests with `memdata` from a 256-byte unified instruction/data store. It also owns the boot sequence: after reset it holds the core in reset while a byte-stream loader fills memory, then releases the core. One address is memory-mapped as an output register for observing program results.

## Interface
Parameters:
- `DEPTH`, 256: memory bytes; address width is fixed at 8.
- `IO_ADDR`, 8'hFF: memory-mapped output register address; never backed by RAM.
- `CNT_WIDTH`, 16: width of the run-cycle counter.

Ports:
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `reset`, in, 1: synchronous, active-low.
- `adr`, in, 8: core byte address.
- `writedata`, in, 8: core store data.
- `memwrite`, in, 1: core store strobe.
- `memdata`, out, 8: read data to the core.
- `load_valid`, in, 1: loader byte valid.
- `load_data`, in, 8: loader byte.
- `load_last`, in, 1: qualifies the final loader byte.
- `load_ready`, out, 1: loader byte accepted when `load_valid & load_ready`.
- `cpu_reset`, out, 1: active-high reset driven to the core.
- `io_out`, out, 8: output register contents.
- `io_strobe`, out, 1: one-cycle pulse on each store to `IO_ADDR`.
- `load_wrap`, out, 1: sticky flag; the load pointer wrapped past 255.
- `run_cycles`, out, CNT_WIDTH: cycles spent in RUN, saturating.

## Operation
- FSM states: LOAD and RUN.
- Reset (`reset`=0 at an edge) forces:
  - state LOAD, load pointer 0;
  - `cpu_reset`=1, `io_out`=0, `io_strobe`=0, `load_wrap`=0, `run_cycles`=0.
  - RAM contents are NOT cleared.
- LOAD:
  - `load_ready`=1, `cpu_reset`=1, `memdata`=0; `memwrite` is ignored.
  - On each accepted byte: `mem[ptr] <= load_data`, `ptr <= ptr+1` (8-bit wrap).
  - If an accepted byte is written at ptr 255, `load_wrap` sets. Loading continues.
  - A byte accepted with `load_last`=1 is written, and the state moves to RUN on the same edge.
  - The `IO_ADDR` location is written to RAM during load, but that RAM byte is unreachable in RUN.
- RUN:
  - `load_ready`=0; `load_valid` is ignored. `cpu_reset`=0.
  - Read is combinational: `memdata = (adr==IO_ADDR) ? io_out : mem[adr]`.
  - Store, `memwrite`=1 at an edge:
    - if `adr==IO_ADDR`: `io_out <= writedata`, and `io_strobe` is high for the following cycle only;
    - otherwise: `mem[adr] <= writedata`.
  - `run_cycles` increments every RUN cycle and holds at all-ones.
- RUN exits only via reset. There is no return to LOAD otherwise.

## Timing
- Read latency is 0 cycles (combinational from `adr`). The core may sample `memdata` at the edge in the same cycle `adr` is presented.
- Read-during-write, same address: `memdata` shows the old byte in that cycle and the new byte from the next cycle.
- A store takes effect at the edge where `memwrite`=1; `io_out` updates at that edge.
- `io_strobe` asserts the cycle after that edge. Back-to-back IO stores keep it high continuously.
- `cpu_reset` falls in the first cycle after the edge that accepted the `load_last` byte. `run_cycles` reads 1 at the end of that first RUN cycle.
- A loader byte with `load_valid`=1 and `load_ready`=0 is dropped; there is no backpressure in RUN.
- Reset in mid-load or mid-run takes priority over every concurrent load or store at that edge.

## Test plan
- Boot handshake: load 4 bytes 8'h80, 8'h44, 8'h00, 8'h03 with `load_last` on the 4th. Required:
  - `cpu_reset`=1 throughout the load;
  - `cpu_reset`=0 on the next cycle;
  - with `adr`=0..3, `memdata` returns the bytes in order.
- Store/read: in RUN, `memwrite`=1, `adr`=8'h10, `writedata`=8'hA5 for one edge. Required:
  - `memdata` at `adr`=8'h10 equals 8'hA5 next cycle;
  - `io_strobe` stays 0.
- IO register: store 8'h3C to 8'hFF. Required:
  - `io_out`=8'h3C;
  - `io_strobe` high for exactly 1 cycle;
  - a read of 8'hFF returns 8'h3C.
- Wrap and ignore:
  - load 257 bytes (last on #257): `load_wrap`=1, and `mem[0]` holds byte #257;
  - a `load_valid` pulse in RUN leaves memory unchanged.
- Reset mid-run:
  - after 20 RUN cycles (`run_cycles`=20), assert `reset`=0 for one edge;
  - required: `cpu_reset`=1, `io_out`=0, `run_cycles`=0, state LOAD;
  - a previously stored byte at 8'h10 is still 8'hA5 after reloading with a single `load_last` byte.
- Saturation: with `CNT_WIDTH`=4, run 20 cycles. Required: `run_cycles` holds at 4'hF.
